// File: rtl/oled_stream_if.sv
// oled_stream_if: byte stream from oled_stream to the SPI serializer.
// The master offers data/dc/valid and the slave answers with ready.
interface oled_stream_if;
    logic [7:0] data;
    logic       dc;
    logic       valid;
    logic       ready;
    modport master (output data, dc, valid, input ready);
    modport slave  (input data, dc, valid, output ready);
endinterface

// File: rtl/oled_stream.sv
// oled_stream: SSD1306 byte source -- power-up wait, init commands, then per-request framebuffer stream.
// Define OLED_FLIP_EN to add segment remap / COM reverse scan (A1 C8) to the init sequence.
module oled_stream #(
    parameter int         POWERUP_CYCLES = 1000,
    parameter logic [7:0] CONTRAST       = 8'hCF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_req_i,
    output logic [9:0]           fb_addr_o,
    input  logic [7:0]           fb_rdata_i,
    oled_stream_if.master        bs,
    output logic                 init_done_o,
    output logic                 busy_o,
    output logic                 frame_done_o
);
`ifdef OLED_FLIP_EN
    localparam int INIT_N = 12;
    localparam logic [INIT_N*8-1:0] INIT_ROM = {8'h8D, 8'h14, 8'h81, CONTRAST, 8'hD9, 8'hF1,
                                                8'hA4, 8'hA1, 8'hC8, 8'hAF, 8'h20, 8'h00};
`else
    localparam int INIT_N = 10;
    localparam logic [INIT_N*8-1:0] INIT_ROM = {8'h8D, 8'h14, 8'h81, CONTRAST, 8'hD9, 8'hF1,
                                                8'hA4, 8'hAF, 8'h20, 8'h00};
`endif
    localparam logic [47:0] ADDR_ROM = {8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
    localparam int PW = $clog2(POWERUP_CYCLES + 1);

    typedef enum logic [2:0] {PWRUP, INIT, IDLE, ADDR, FETCH, LATCH, SEND} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pwr_q, pwr_d;
    logic [3:0]    idx_q, idx_d;
    logic [9:0]    fb_addr_q, fb_addr_d;
    logic [7:0]    data_q, data_d;
    logic          dc_q, dc_d, valid_q, valid_d, pend_q, pend_d;
    logic          init_done_q, init_done_d, busy_q, busy_d, frame_done_q, frame_done_d;
    logic          hs, go_addr;

    assign hs      = valid_q & bs.ready;
    assign go_addr = pend_q | frame_req_i;

    // fb_addr doubles as the frame byte counter; it only moves on entry to FETCH
    always_comb begin
        state_d      = state_q;
        pwr_d        = pwr_q;
        idx_d        = idx_q;
        fb_addr_d    = fb_addr_q;
        data_d       = data_q;
        dc_d         = dc_q;
        valid_d      = valid_q;
        pend_d       = pend_q | (frame_req_i & (state_q != IDLE));
        init_done_d  = init_done_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        case (state_q)
            PWRUP: begin
                pwr_d   = pwr_q + 1'b1;
                state_d = (pwr_q == PW'(POWERUP_CYCLES - 1)) ? INIT : PWRUP;
            end
            INIT: begin
                if (hs && idx_q == 4'(INIT_N - 1)) begin
                    valid_d     = 1'b0;
                    idx_d       = 4'd0;
                    init_done_d = 1'b1;
                    pend_d      = 1'b0;
                    busy_d      = go_addr;
                    state_d     = go_addr ? ADDR : IDLE;
                end else if (!valid_q || hs) begin
                    idx_d   = idx_q + {3'b0, hs};
                    data_d  = INIT_ROM[8*(INIT_N-1-int'(idx_d)) +: 8];
                    dc_d    = 1'b0;
                    valid_d = 1'b1;
                end
            end
            IDLE: begin
                busy_d  = frame_req_i;
                state_d = frame_req_i ? ADDR : IDLE;
            end
            ADDR: begin
                if (hs && idx_q == 4'd5) begin
                    valid_d   = 1'b0;
                    idx_d     = 4'd0;
                    fb_addr_d = 10'd0;
                    state_d   = FETCH;
                end else if (!valid_q || hs) begin
                    idx_d   = idx_q + {3'b0, hs};
                    data_d  = ADDR_ROM[8*(5-int'(idx_d)) +: 8];
                    dc_d    = 1'b0;
                    valid_d = 1'b1;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                data_d  = fb_rdata_i;
                dc_d    = 1'b1;
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (hs) begin
                    valid_d = 1'b0;
                    if (fb_addr_q != 10'h3FF) begin
                        fb_addr_d = fb_addr_q + 10'd1;
                        state_d   = FETCH;
                    end else begin
                        frame_done_d = 1'b1;
                        pend_d       = 1'b0;
                        busy_d       = go_addr;
                        state_d      = go_addr ? ADDR : IDLE;
                    end
                end
            end
            default: state_d = PWRUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PWRUP;
            pwr_q        <= '0;
            idx_q        <= 4'd0;
            fb_addr_q    <= 10'd0;
            data_q       <= 8'h00;
            dc_q         <= 1'b0;
            valid_q      <= 1'b0;
            pend_q       <= 1'b0;
            init_done_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pwr_q        <= pwr_d;
            idx_q        <= idx_d;
            fb_addr_q    <= fb_addr_d;
            data_q       <= data_d;
            dc_q         <= dc_d;
            valid_q      <= valid_d;
            pend_q       <= pend_d;
            init_done_q  <= init_done_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fb_addr_o    = fb_addr_q;
    assign bs.data      = data_q;
    assign bs.dc        = dc_q;
    assign bs.valid     = valid_q;
    assign init_done_o  = init_done_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
endmodule

// File: tb/tb_oled_stream.sv
// tb_oled_stream: directed bench for oled_stream with a registered-read framebuffer returning addr[7:0].
module tb_oled_stream;
    localparam int P = 4;
`ifdef OLED_FLIP_EN
    localparam int INIT_N = 12;
    logic [7:0] init_exp [12] = '{8'h8D, 8'h14, 8'h81, 8'hCF, 8'hD9, 8'hF1,
                                  8'hA4, 8'hA1, 8'hC8, 8'hAF, 8'h20, 8'h00};
`else
    localparam int INIT_N = 10;
    logic [7:0] init_exp [10] = '{8'h8D, 8'h14, 8'h81, 8'hCF, 8'hD9, 8'hF1,
                                  8'hA4, 8'hAF, 8'h20, 8'h00};
`endif
    logic [7:0] addr_exp [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_req = 1'b0;
    logic [9:0] fb_addr;
    logic [7:0] fb_rdata = 8'h00;
    logic       init_done, busy, frame_done;
    int         n_chk = 0;
    int         n_fail = 0;
    int         fd_cnt = 0;

    oled_stream_if bs();

    oled_stream #(.POWERUP_CYCLES(P)) dut (
        .clk(clk), .rst_n(rst_n), .frame_req_i(frame_req),
        .fb_addr_o(fb_addr), .fb_rdata_i(fb_rdata), .bs(bs),
        .init_done_o(init_done), .busy_o(busy), .frame_done_o(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) fb_rdata <= fb_addr[7:0];
    always @(posedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits for the next handshake; n is the number of cycles it took. Checks stall stability.
    task automatic next_byte(input int pct, output logic [7:0] d, output logic dc, output int n);
        logic       st;
        logic [7:0] sd;
        logic       sdc;
        st = 1'b0; sd = 8'h00; sdc = 1'b0;
        n = 0; d = 8'h00; dc = 1'b0;
        forever begin
            @(negedge clk);
            frame_req = 1'b0;
            n++;
            if (st) begin
                chk("stall_data", 32'(bs.data), 32'(sd));
                chk("stall_dc", 32'(bs.dc), 32'(sdc));
            end
            bs.ready = (int'($urandom_range(99)) < pct);
            if (bs.valid && bs.ready) begin
                d = bs.data; dc = bs.dc;
                return;
            end
            st = bs.valid; sd = bs.data; sdc = bs.dc;
            if (n >= 200) begin
                n_chk++; n_fail++;
                $error("FAIL byte_timeout: waited %0d cycles, required fewer than 200", n);
                return;
            end
        end
    endtask

    task automatic reset_and_init(input int req_after);
        logic [7:0] d;
        logic       dc;
        int         n;
        rst_n = 1'b0; frame_req = 1'b0; bs.ready = 1'b1;
        #1;
        chk("rst_valid", 32'(bs.valid), 32'd0);
        chk("rst_data", 32'(bs.data), 32'h00);
        chk("rst_dc", 32'(bs.dc), 32'd0);
        chk("rst_fb_addr", 32'(fb_addr), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= P; k++) begin
            @(posedge clk); #1;
            chk("pwrup_no_valid", 32'(bs.valid), 32'd0);
        end
        @(posedge clk); #1;
        chk("first_valid", 32'(bs.valid), 32'd1);
        chk("first_byte", 32'(bs.data), 32'h8D);
        for (int i = 0; i < INIT_N; i++) begin
            next_byte(100, d, dc, n);
            chk("init_byte", 32'(d), 32'(init_exp[i]));
            chk("init_dc", 32'(dc), 32'd0);
            chk("init_done_early", 32'(init_done), 32'd0);
            chk("init_busy", 32'(busy), 32'd0);
            if (i > 0) chk("init_back_to_back", 32'(n), 32'd1);
            if (i == req_after) frame_req = 1'b1;
        end
        @(posedge clk); #1;
        chk("init_done", 32'(init_done), 32'd1);
        chk("post_init_busy", 32'(busy), 32'(req_after >= 0));
    endtask

    task automatic run_frame(input int pct, input bit mid_req, input bit end_req, input int abort_at);
        logic [7:0] d;
        logic       dc;
        int         n;
        for (int i = 0; i < 6; i++) begin
            next_byte(pct, d, dc, n);
            chk("addr_byte", 32'(d), 32'(addr_exp[i]));
            chk("addr_dc", 32'(dc), 32'd0);
            chk("addr_busy", 32'(busy), 32'd1);
            if (i > 0 && pct == 100) chk("addr_back_to_back", 32'(n), 32'd1);
        end
        for (int i = 0; i < 1024; i++) begin
            next_byte(pct, d, dc, n);
            chk("data_byte", 32'(d), 32'(i % 256));
            chk("data_dc", 32'(dc), 32'd1);
            if (pct == 100) chk("data_period", 32'(n), 32'd3);
            if (i == abort_at) return;
            if (mid_req && (i == 100 || i == 200 || i == 300)) frame_req = 1'b1;
            if (end_req && i == 1023) frame_req = 1'b1;
        end
        @(posedge clk); #1;
        frame_req = 1'b0;
        chk("frame_done_pulse", 32'(frame_done), 32'd1);
        chk("frame_end_busy", 32'(busy), 32'(mid_req | end_req));
        @(posedge clk); #1;
        chk("frame_done_single", 32'(frame_done), 32'd0);
    endtask

    task automatic idle_check(input int cycles);
        int v;
        v = 0;
        repeat (cycles) begin
            @(negedge clk);
            frame_req = 1'b0;
            if (bs.valid) v++;
        end
        chk("idle_no_valid", 32'(v), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        bs.ready = 1'b1;
        #1;
        reset_and_init(-1);
        @(negedge clk); frame_req = 1'b1;
        run_frame(100, 1'b0, 1'b0, -1);
        idle_check(20);
        @(negedge clk); frame_req = 1'b1;
        run_frame(30, 1'b1, 1'b0, -1);
        run_frame(100, 1'b0, 1'b1, -1);
        run_frame(100, 1'b0, 1'b0, 500);
        reset_and_init(-1);
        idle_check(50);
        reset_and_init(3);
        run_frame(100, 1'b0, 1'b0, -1);
        idle_check(50);
        chk("frame_done_count", 32'(fd_cnt), 32'd4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/oled_stream.md
# oled_stream

Byte-level source for the SSD1306 128x64 OLED link. It sits directly upstream of the SPI byte serializer. After reset it emits the display power-up command sequence, then streams one full framebuffer per frame request. Each frame is six address-window commands followed by 1024 pixel bytes, read from a synchronous framebuffer RAM. Every byte carries a data/command flag and is handed to the serializer over a valid/ready handshake.

## Interface
Parameters:
- POWERUP_CYCLES, 1000: idle cycles after reset release before the first command byte.
- CONTRAST, 8'hCF: contrast value sent after command 8'h81.

Ports:
- clk, in, 1: system clock, all state on rising edge.
- rst_n, in, 1: reset is asynchronous and active-low.
- frame_req, in, 1: single-cycle pulse requesting one frame transfer.
- fb_addr, out, 10: framebuffer read address, registered.
- fb_rdata, in, 8: framebuffer read data; RAM registers fb_addr at a rising edge and presents data for the whole following cycle.
- byte_data, out, 8: byte offered to the serializer.
- byte_dc, out, 1: 0 = command, 1 = display data.
- byte_valid, out, 1: byte_data/byte_dc are valid.
- byte_ready, in, 1: serializer accepts the byte.
- init_done, out, 1: init sequence fully handed off.
- busy, out, 1: a frame transfer is in progress.
- frame_done, out, 1: one-cycle pulse at the end of a frame.

## Operation
- States: PWRUP, INIT, IDLE, ADDR, FETCH, LATCH, SEND.
- PWRUP: count POWERUP_CYCLES cycles, then go to INIT.
- INIT: send the ROM bytes in order, all with byte_dc=0: 8D 14 81 CONTRAST D9 F1 A4 AF 20 00. That is 10 bytes.
  - After the last handshake, set init_done and go to IDLE, or to ADDR if a request is pending.
- ADDR: send 21 00 7F 22 00 07 with byte_dc=0, then set the byte counter to 0 and go to FETCH.
- FETCH: fb_addr = byte counter; byte_valid=0.
- LATCH: at the end of the cycle, capture fb_rdata into byte_data with byte_dc=1.
- SEND: hold byte_valid=1 until handshake.
  - If the counter < 1023: increment the counter and go to FETCH.
  - Else: pulse frame_done, clear busy, and go to IDLE, or to ADDR if a request is pending.
- Handshake: a transfer occurs on a rising edge where byte_valid & byte_ready.
  - While byte_valid & ~byte_ready, byte_data and byte_dc must not change.
  - byte_ready without byte_valid is ignored.
- Pending request:
  - A one-bit flag, set by frame_req in any state other than IDLE (including PWRUP and INIT).
  - Cleared on entry to ADDR.
  - Multiple requests while the flag is set coalesce into one frame.
- frame_req in IDLE: enter ADDR on the next edge.
- busy: 1 from ADDR entry through the final SEND handshake; 0 otherwise.
- fb_addr holds its last value outside FETCH.
- Byte counter: 10 bits; a frame ends at 1023, never wraps.

## Timing
- Reset values: byte_valid=0, byte_data=8'h00, byte_dc=0, fb_addr=0, init_done=0, busy=0, frame_done=0. State = PWRUP, pending flag = 0, counters = 0.
- Outputs take reset values immediately on rst_n falling, independent of clk.
- First byte_valid (8'h8D) rises on the (POWERUP_CYCLES+1)th rising edge after rst_n release.
- Command bytes (INIT, ADDR) are back-to-back: after a handshake, the next byte is valid in the following cycle with byte_valid continuously high.
- Data bytes: handshake at edge E, then FETCH at E+1, LATCH at E+2, byte_valid rises at E+3. The minimum byte period is 3 cycles, which the serializer's 8+ cycles per byte hides.
- init_done rises the cycle after the 10th init handshake and stays high until reset.
- frame_done is high for exactly the cycle after the 1024th data handshake.
- frame_req is sampled in the same edge as a final handshake: it sets pending, and the block goes to ADDR.
- Reset mid-operation aborts the frame, drops the pending flag, and reruns PWRUP and INIT.

## Configuration
- OLED_FLIP_EN defined: the init ROM inserts A1 C8 between A4 and AF, giving 12 bytes. This sets segment remap and COM reverse scan for the upside-down panel mount; init_done follows the 12th handshake.
- Not defined: the 10-byte sequence above; no remap bytes are ever emitted.

## Test plan
- POWERUP_CYCLES=4, byte_ready=1 -> first valid on the 5th edge. Handshaked bytes are 8D 14 81 CF D9 F1 A4 AF 20 00, all dc=0. init_done rises the next cycle; busy stays 0.
- After init, pulse frame_req with RAM model fb_rdata = addr[7:0] -> 21 00 7F 22 00 07 (dc=0), then 1024 bytes 00..FF repeating four times (dc=1), one frame_done pulse, busy low after.
- Random byte_ready (about 30% high) during a frame -> byte_data/byte_dc stable under stall, and the sequence is identical to the previous test.
- Three frame_req pulses mid-frame plus one during INIT -> exactly one further frame after each current transfer, no extra frames.
- rst_n low at data byte 500 -> all outputs at reset values before the next clk edge. After release, INIT reruns and no data bytes are emitted without a new frame_req.
- OLED_FLIP_EN defined -> init stream 8D 14 81 CF D9 F1 A4 A1 C8 AF 20 00, and init_done follows the 12th handshake.
